// File: rtl/bsg_manycore_link_pipe.sv
// bsg_manycore_link_pipe: registered 2-entry elastic stage for a mesh link.
// Forward (A->B) and reverse (B->A) directions run independently.
module bsg_manycore_link_pipe_stage #(
  parameter int width_p     = 32,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   ready_i,
  input  logic                   stall_clear_i,
  output logic [cnt_width_p-1:0] stall_cnt_o
);

  logic [width_p-1:0]     mem_q [2];
  logic                   head_q;
  logic                   tail_q;
  logic                   init_q;
  logic [1:0]             occ_q;
  logic [cnt_width_p-1:0] cnt_q;
  logic                   enq;
  logic                   deq;

  assign ready_o     = init_q & (occ_q != 2'd2);
  assign v_o         = (occ_q != 2'd0);
  assign data_o      = mem_q[head_q];
  assign stall_cnt_o = cnt_q;
  assign enq         = v_i & ready_o;
  assign deq         = v_o & ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      init_q   <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      // ready stays low for the release cycle
      init_q <= 1'b1;
      if (enq) begin
        mem_q[tail_q] <= data_i;
        tail_q        <= ~tail_q;
      end
      if (deq) begin
        head_q <= ~head_q;
      end
      unique case (1'b1)
        enq & ~deq: occ_q <= occ_q + 2'd1;
        deq & ~enq: occ_q <= occ_q - 2'd1;
        default:    occ_q <= occ_q;
      endcase
      if (stall_clear_i) begin
        cnt_q <= '0;
      end else if (v_o & ~ready_i & (cnt_q != '1)) begin
        cnt_q <= cnt_q + cnt_width_p'(1);
      end
    end
  end

endmodule

module bsg_manycore_link_pipe #(
  parameter int fwd_width_p       = 32,
  parameter int rev_width_p       = 32,
  parameter int stall_cnt_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         a_fwd_v_i,
  input  logic [fwd_width_p-1:0]       a_fwd_data_i,
  output logic                         a_fwd_ready_o,
  output logic                         b_fwd_v_o,
  output logic [fwd_width_p-1:0]       b_fwd_data_o,
  input  logic                         b_fwd_ready_i,
  input  logic                         b_rev_v_i,
  input  logic [rev_width_p-1:0]       b_rev_data_i,
  output logic                         b_rev_ready_o,
  output logic                         a_rev_v_o,
  output logic [rev_width_p-1:0]       a_rev_data_o,
  input  logic                         a_rev_ready_i,
  input  logic                         stall_clear_i,
  output logic [stall_cnt_width_p-1:0] fwd_stall_cnt_o,
  output logic [stall_cnt_width_p-1:0] rev_stall_cnt_o
);

  bsg_manycore_link_pipe_stage #(
    .width_p     (fwd_width_p),
    .cnt_width_p (stall_cnt_width_p)
  ) fwd_stage (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .v_i           (a_fwd_v_i),
    .data_i        (a_fwd_data_i),
    .ready_o       (a_fwd_ready_o),
    .v_o           (b_fwd_v_o),
    .data_o        (b_fwd_data_o),
    .ready_i       (b_fwd_ready_i),
    .stall_clear_i (stall_clear_i),
    .stall_cnt_o   (fwd_stall_cnt_o)
  );

  bsg_manycore_link_pipe_stage #(
    .width_p     (rev_width_p),
    .cnt_width_p (stall_cnt_width_p)
  ) rev_stage (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .v_i           (b_rev_v_i),
    .data_i        (b_rev_data_i),
    .ready_o       (b_rev_ready_o),
    .v_o           (a_rev_v_o),
    .data_o        (a_rev_data_o),
    .ready_i       (a_rev_ready_i),
    .stall_clear_i (stall_clear_i),
    .stall_cnt_o   (rev_stall_cnt_o)
  );

endmodule

// File: tb/tb_bsg_manycore_link_pipe.sv
// Testbench for bsg_manycore_link_pipe: directed table, corner
// sequences and a randomized scoreboard on both directions.
module tb_bsg_manycore_link_pipe;

  localparam int FW = 8;
  localparam int RW = 12;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          a_fwd_v_i = 1'b0;
  logic [FW-1:0] a_fwd_data_i = '0;
  logic          a_fwd_ready_o;
  logic          b_fwd_v_o;
  logic [FW-1:0] b_fwd_data_o;
  logic          b_fwd_ready_i = 1'b0;
  logic          b_rev_v_i = 1'b0;
  logic [RW-1:0] b_rev_data_i = '0;
  logic          b_rev_ready_o;
  logic          a_rev_v_o;
  logic [RW-1:0] a_rev_data_o;
  logic          a_rev_ready_i = 1'b1;
  logic          stall_clear_i = 1'b0;
  logic [CW-1:0] fwd_stall_cnt_o;
  logic [CW-1:0] rev_stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_manycore_link_pipe #(
    .fwd_width_p       (FW),
    .rev_width_p       (RW),
    .stall_cnt_width_p (CW)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .a_fwd_v_i       (a_fwd_v_i),
    .a_fwd_data_i    (a_fwd_data_i),
    .a_fwd_ready_o   (a_fwd_ready_o),
    .b_fwd_v_o       (b_fwd_v_o),
    .b_fwd_data_o    (b_fwd_data_o),
    .b_fwd_ready_i   (b_fwd_ready_i),
    .b_rev_v_i       (b_rev_v_i),
    .b_rev_data_i    (b_rev_data_i),
    .b_rev_ready_o   (b_rev_ready_o),
    .a_rev_v_o       (a_rev_v_o),
    .a_rev_data_o    (a_rev_data_o),
    .a_rev_ready_i   (a_rev_ready_i),
    .stall_clear_i   (stall_clear_i),
    .fwd_stall_cnt_o (fwd_stall_cnt_o),
    .rev_stall_cnt_o (rev_stall_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          av;
    logic [FW-1:0] ad;
    logic          br;
    logic          er;
    logic          ev;
    logic          cd;
    logic [FW-1:0] ed;
    logic [CW-1:0] ec;
  } vec_t;

  function automatic vec_t mk(logic av, logic [FW-1:0] ad, logic br,
                              logic er, logic ev, logic cd,
                              logic [FW-1:0] ed, logic [CW-1:0] ec);
    vec_t v;
    v.av = av; v.ad = ad; v.br = br; v.er = er;
    v.ev = ev; v.cd = cd; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  vec_t tbl [13];

  logic [FW-1:0] fwd_q [$];
  logic [RW-1:0] rev_q [$];

  initial begin
    logic          f_acc, r_acc, gen;
    logic [FW-1:0] f_seq;
    logic [RW-1:0] r_seq;
    logic [FW-1:0] fexp;
    logic [RW-1:0] rexp;
    int            delivered;

    // row: av ad br | exp ready, valid, check-data, data, stall count
    tbl[0]  = mk(1, 8'h01, 1, 0, 0, 1, 8'h00, 0);
    tbl[1]  = mk(1, 8'h01, 1, 1, 0, 1, 8'h00, 0);
    tbl[2]  = mk(1, 8'h02, 1, 1, 1, 1, 8'h01, 0);
    tbl[3]  = mk(1, 8'h03, 1, 1, 1, 1, 8'h02, 0);
    tbl[4]  = mk(0, 8'h00, 1, 1, 1, 1, 8'h03, 0);
    tbl[5]  = mk(1, 8'h0A, 0, 1, 0, 0, 8'h00, 0);
    tbl[6]  = mk(1, 8'h0B, 0, 1, 1, 1, 8'h0A, 0);
    tbl[7]  = mk(1, 8'h0C, 0, 0, 1, 1, 8'h0A, 1);
    tbl[8]  = mk(1, 8'h0C, 0, 0, 1, 1, 8'h0A, 2);
    tbl[9]  = mk(1, 8'h0C, 1, 0, 1, 1, 8'h0A, 3);
    tbl[10] = mk(1, 8'h0C, 1, 1, 1, 1, 8'h0B, 3);
    tbl[11] = mk(0, 8'h00, 1, 1, 1, 1, 8'h0C, 3);
    tbl[12] = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 3);

    repeat (3) @(negedge clk_i);
    chk("rst_fwd_ready", a_fwd_ready_o, 0);
    chk("rst_fwd_v", b_fwd_v_o, 0);
    chk("rst_fwd_data", b_fwd_data_o, 0);
    chk("rst_rev_ready", b_rev_ready_o, 0);
    chk("rst_rev_v", a_rev_v_o, 0);
    chk("rst_rev_data", a_rev_data_o, 0);
    chk("rst_fwd_cnt", fwd_stall_cnt_o, 0);
    chk("rst_rev_cnt", rev_stall_cnt_o, 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      if (i == 0) reset_i = 1'b1;
      a_fwd_v_i     = tbl[i].av;
      a_fwd_data_i  = tbl[i].ad;
      b_fwd_ready_i = tbl[i].br;
      #1;
      chk($sformatf("tbl_ready[%0d]", i), a_fwd_ready_o, tbl[i].er);
      chk($sformatf("tbl_v[%0d]", i), b_fwd_v_o, tbl[i].ev);
      if (tbl[i].cd)
        chk($sformatf("tbl_data[%0d]", i), b_fwd_data_o, tbl[i].ed);
      chk($sformatf("tbl_cnt[%0d]", i), fwd_stall_cnt_o, tbl[i].ec);
    end
    chk("rev_idle_v", a_rev_v_o, 0);
    chk("rev_idle_cnt", rev_stall_cnt_o, 0);

    @(negedge clk_i);
    stall_clear_i = 1'b1;
    @(negedge clk_i);
    stall_clear_i = 1'b0;
    #1 chk("fwd_clear", fwd_stall_cnt_o, 0);

    // reverse saturation with a full buffer
    @(negedge clk_i);
    b_rev_v_i = 1'b1; b_rev_data_i = 12'h5A1; a_rev_ready_i = 1'b0;
    #1 chk("rev_ready_empty", b_rev_ready_o, 1);
    @(negedge clk_i);
    b_rev_data_i = 12'h5A2;
    #1 chk("rev_ready_one", b_rev_ready_o, 1);
    @(negedge clk_i);
    b_rev_v_i = 1'b0;
    #1;
    chk("rev_full_ready", b_rev_ready_o, 0);
    chk("rev_full_v", a_rev_v_o, 1);
    chk("rev_full_data", a_rev_data_o, 12'h5A1);
    chk("rev_cnt_1", rev_stall_cnt_o, 1);
    repeat (9) @(negedge clk_i);
    #1 chk("rev_cnt_10", rev_stall_cnt_o, 10);
    repeat (66000) @(negedge clk_i);
    #1;
    chk("rev_cnt_sat", rev_stall_cnt_o, 16'hFFFF);
    chk("rev_hold_data", a_rev_data_o, 12'h5A1);
    chk("fwd_cnt_indep", fwd_stall_cnt_o, 0);
    @(negedge clk_i);
    stall_clear_i = 1'b1;
    @(negedge clk_i);
    stall_clear_i = 1'b0;
    #1 chk("rev_clear_prio", rev_stall_cnt_o, 0);
    @(negedge clk_i);
    #1 chk("rev_cnt_resume", rev_stall_cnt_o, 1);
    a_rev_ready_i = 1'b1;
    #1 chk("rev_drain0", a_rev_data_o, 12'h5A1);
    @(negedge clk_i);
    #1 chk("rev_drain1", a_rev_data_o, 12'h5A2);
    chk("rev_drain1_v", a_rev_v_o, 1);
    @(negedge clk_i);
    #1 chk("rev_drained_v", a_rev_v_o, 0);

    // fill both directions, then asynchronous reset mid-cycle
    @(negedge clk_i);
    a_fwd_v_i = 1'b1; a_fwd_data_i = 8'h11; b_fwd_ready_i = 1'b0;
    b_rev_v_i = 1'b1; b_rev_data_i = 12'h211; a_rev_ready_i = 1'b0;
    @(negedge clk_i);
    a_fwd_data_i = 8'h12; b_rev_data_i = 12'h212;
    @(negedge clk_i);
    a_fwd_v_i = 1'b0; b_rev_v_i = 1'b0;
    #1;
    chk("fill_fwd_ready", a_fwd_ready_o, 0);
    chk("fill_rev_ready", b_rev_ready_o, 0);
    @(posedge clk_i);
    #2 reset_i = 1'b0;
    #1;
    chk("arst_fwd_v", b_fwd_v_o, 0);
    chk("arst_rev_v", a_rev_v_o, 0);
    chk("arst_fwd_ready", a_fwd_ready_o, 0);
    chk("arst_rev_ready", b_rev_ready_o, 0);
    chk("arst_fwd_cnt", fwd_stall_cnt_o, 0);
    chk("arst_rev_cnt", rev_stall_cnt_o, 0);
    chk("arst_fwd_data", b_fwd_data_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    a_fwd_v_i = 1'b1; a_fwd_data_i = 8'h33; b_fwd_ready_i = 1'b1;
    b_rev_v_i = 1'b1; b_rev_data_i = 12'h433; a_rev_ready_i = 1'b1;
    #1 chk("rel_fwd_ready", a_fwd_ready_o, 0);
    @(negedge clk_i);
    #1;
    chk("rel2_fwd_ready", a_fwd_ready_o, 1);
    chk("rel2_fwd_v", b_fwd_v_o, 0);
    @(negedge clk_i);
    a_fwd_v_i = 1'b0; b_rev_v_i = 1'b0;
    #1;
    chk("new_fwd_v", b_fwd_v_o, 1);
    chk("new_fwd_data", b_fwd_data_o, 8'h33);
    chk("new_rev_v", a_rev_v_o, 1);
    chk("new_rev_data", a_rev_data_o, 12'h433);
    @(negedge clk_i);
    #1 chk("new_fwd_once", b_fwd_v_o, 0);
    chk("new_rev_once", a_rev_v_o, 0);

    // randomized traffic against a scoreboard
    f_acc = 1'b1; r_acc = 1'b1; gen = 1'b1;
    f_seq = 8'h40; r_seq = 12'h800; delivered = 0;
    for (int c = 0; c < 3030; c++) begin
      @(negedge clk_i);
      if (c == 3000) gen = 1'b0;
      if (!a_fwd_v_i || f_acc) begin
        a_fwd_v_i = gen & ($urandom_range(0, 1) == 1);
        a_fwd_data_i = f_seq;
      end
      if (!b_rev_v_i || r_acc) begin
        b_rev_v_i = gen & ($urandom_range(0, 1) == 1);
        b_rev_data_i = r_seq;
      end
      b_fwd_ready_i = !gen || ($urandom_range(0, 3) != 0);
      a_rev_ready_i = !gen || ($urandom_range(0, 2) != 0);
      #1;
      if (b_fwd_v_o && b_fwd_ready_i) begin
        fexp = (fwd_q.size() > 0) ? fwd_q.pop_front() : 8'hXX;
        chk("rnd_fwd_data", b_fwd_data_o, fexp);
        delivered++;
      end
      if (a_rev_v_o && a_rev_ready_i) begin
        rexp = (rev_q.size() > 0) ? rev_q.pop_front() : 12'hXXX;
        chk("rnd_rev_data", a_rev_data_o, rexp);
        delivered++;
      end
      f_acc = a_fwd_v_i && a_fwd_ready_o;
      r_acc = b_rev_v_i && b_rev_ready_o;
      if (f_acc) begin
        fwd_q.push_back(a_fwd_data_i);
        f_seq = f_seq + 8'd1;
      end
      if (r_acc) begin
        rev_q.push_back(b_rev_data_i);
        r_seq = r_seq + 12'd1;
      end
    end
    chk("rnd_fwd_left", fwd_q.size(), 0);
    chk("rnd_rev_left", rev_q.size(), 0);
    chk("rnd_enough", delivered > 1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
